// File: rtl/event_fifo_irq.sv
`default_nettype none
// ============================================================================
// Module   : event_fifo_irq
// Purpose  : Pixel-event FIFO with hysteresis service IRQ and drop tracking.
//            Optional macro FIFO_DROP_CNT_EN enables the saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module event_fifo_irq #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_clr,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  irq_assert_thresh,
  input  logic [CNT_W-1:0]  irq_deassert_thresh,
  output logic              irq,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ASSERT = 1'b1
  } irq_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  irq_state_t        state_q, state_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Full/empty come from the registered count, so a pop cannot make room
  // for a push in the same cycle.
  assign w_full  = (count_q == C_FULL_CNT);
  assign w_empty = (count_q == '0);
  assign w_push  = wr_valid && !w_full && !fifo_clr;
  assign w_pop   = rd_en && !w_empty && !fifo_clr;
  assign w_drop  = wr_valid && w_full && !fifo_clr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem[wptr_q] <= wr_data;
    end
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    if (fifo_clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (w_push) begin
        wptr_d = wptr_q + ADDR_W'(1);
      end
      if (w_pop) begin
        rptr_d     = rptr_q + ADDR_W'(1);
        rd_data_d  = mem[rptr_q];
        rd_valid_d = 1'b1;
      end
      if (w_drop) begin
        overflow_d = 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Hysteresis IRQ: compares the registered count, so irq trails count by one cycle.
  always_comb begin
    state_d = state_q;
    if (fifo_clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (count_q >= irq_assert_thresh)   state_d = ST_ASSERT;
        ST_ASSERT: if (count_q <= irq_deassert_thresh) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (fifo_clr) begin
      drop_cnt_d = '0;
    end else if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0;
`endif

  assign wr_ready = !w_full;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign irq      = (state_q == ST_ASSERT);

endmodule
`default_nettype wire
